// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port integer register file.
//   REG_ZERO      : index of the hard-wired zero register
//   A0_IDX/A1_IDX : ABI argument registers, handy for directed benches
//   rf_addr_t     : register index at the default address width
//   rf_data_t     : register value at the default data width
package rf_pkg;

  localparam int ADDRESS_WIDTH_DEF = 5;
  localparam int DATA_WIDTH_DEF    = 32;

  localparam int REG_ZERO = 0;
  localparam int A0_IDX   = 10;
  localparam int A1_IDX   = 11;

  typedef logic [ADDRESS_WIDTH_DEF-1:0] rf_addr_t;
  typedef logic [DATA_WIDTH_DEF-1:0]    rf_data_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard for issue-stage hazard checks.
//   clk, rst   : clock, synchronous active-high reset (clears every busy bit)
//   iss_valid  : per issue port, marks iss_rd busy at the next edge
//   iss_rd     : destination register per issue port
//   clr_en     : per write port, clears busy[clr_addr] at the next edge
//   clr_addr   : write address per write port
//   rd_addr    : read address per read port
//   rd_busy    : busy bit of rd_addr, from the registered vector
// Register 0 is never marked busy. A set and a clear hitting the same
// register in one cycle leave it busy: the issue is a newer producer.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 5,
  parameter int NUM_RD        = 4,
  parameter int NUM_WR        = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_WR-1:0]                     iss_valid,
  input  logic [NUM_WR-1:0][ADDRESS_WIDTH-1:0]  iss_rd,
  input  logic [NUM_WR-1:0]                     clr_en,
  input  logic [NUM_WR-1:0][ADDRESS_WIDTH-1:0]  clr_addr,
  input  logic [NUM_RD-1:0][ADDRESS_WIDTH-1:0]  rd_addr,
  output logic [NUM_RD-1:0]                     rd_busy
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] ZERO_ADDR = ADDRESS_WIDTH'(REG_ZERO);

  logic [DEPTH-1:0] busy_q, busy_d, set_vec, clr_vec;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int j = 0; j < NUM_WR; j++)
      if (iss_valid[j] && iss_rd[j] != ZERO_ADDR) set_vec[iss_rd[j]] = 1'b1;
    for (int i = 0; i < NUM_WR; i++)
      if (clr_en[i] && clr_addr[i] != ZERO_ADDR) clr_vec[clr_addr[i]] = 1'b1;
    // clear first, then set, so a same-cycle issue keeps the bit
    busy_d = (busy_q & ~clr_vec) | set_vec;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    assign rd_busy[k] = busy_q[rd_addr[k]];
  end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port integer register file (NUM_RD reads, NUM_WR writes).
//   clk, rst    : clock, synchronous active-high reset
//   raddr/rdata : combinational read ports, port k at slice k
//   rready      : per read port, operand not waiting on an in-flight producer
//   we/waddr/wdata : write ports; lowest index wins on a same-address clash
//   iss_valid/iss_rd : issue ports, mark the destination busy
//   dbg_addr/dbg_data : stored-value tap, never bypassed
//   wr_conflict : registered one-cycle pulse after a same-address write clash
// Register 0 reads as zero, is never written and is never busy.
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_RD        = 4,
  parameter int NUM_WR        = 2,
  parameter int BYPASS        = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_RD*ADDRESS_WIDTH-1:0]   raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0]      rdata,
  output logic [NUM_RD-1:0]                 rready,
  input  logic [NUM_WR-1:0]                 we,
  input  logic [NUM_WR*ADDRESS_WIDTH-1:0]   waddr,
  input  logic [NUM_WR*DATA_WIDTH-1:0]      wdata,
  input  logic [NUM_WR-1:0]                 iss_valid,
  input  logic [NUM_WR*ADDRESS_WIDTH-1:0]   iss_rd,
  input  logic [ADDRESS_WIDTH-1:0]          dbg_addr,
  output logic [DATA_WIDTH-1:0]             dbg_data,
  output logic                              wr_conflict
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] ZERO_ADDR = ADDRESS_WIDTH'(REG_ZERO);

  if (NUM_RD < 1 || NUM_RD > 8 || NUM_WR < 1 || NUM_WR > 4 ||
      ADDRESS_WIDTH < 1 || DATA_WIDTH < 1 || (BYPASS != 0 && BYPASS != 1)) begin : g_param_chk
    $error("reg_file_mp: parameter out of range");
  end

  logic [NUM_RD-1:0][ADDRESS_WIDTH-1:0] ra;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0]    rd;
  logic [NUM_WR-1:0][ADDRESS_WIDTH-1:0] wa;
  logic [NUM_WR-1:0][DATA_WIDTH-1:0]    wd;
  logic [NUM_WR-1:0][ADDRESS_WIDTH-1:0] ir;

  assign ra    = raddr;
  assign wa    = waddr;
  assign wd    = wdata;
  assign ir    = iss_rd;
  assign rdata = rd;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
  logic [NUM_WR-1:0]                wr_live;
  logic                             conflict;
  logic                             conflict_q;
  logic [NUM_RD-1:0]                rd_busy;

  // a write only counts when it targets a real register
  for (genvar i = 0; i < NUM_WR; i++) begin : g_live
    assign wr_live[i] = we[i] && (wa[i] != ZERO_ADDR);
  end

  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < NUM_WR; i++)
      for (int j = i + 1; j < NUM_WR; j++)
        if (wr_live[i] && wr_live[j] && wa[i] == wa[j]) conflict = 1'b1;
  end

  // Walk ports high to low: the last nonblocking assignment to an entry
  // sticks, which hands a same-address clash to the lowest port.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q      <= '0;
      conflict_q <= 1'b0;
    end else begin
      for (int i = NUM_WR - 1; i >= 0; i--)
        if (wr_live[i]) mem_q[wa[i]] <= wd[i];
      conflict_q <= conflict;
    end
  end

  assign wr_conflict = conflict_q;
  assign dbg_data    = (dbg_addr == ZERO_ADDR) ? '0 : mem_q[dbg_addr];

  rf_scoreboard #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .NUM_RD        (NUM_RD),
    .NUM_WR        (NUM_WR)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_rd    (ir),
    .clr_en    (we),
    .clr_addr  (wa),
    .rd_addr   (ra),
    .rd_busy   (rd_busy)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic                  fwd_hit;
    logic [DATA_WIDTH-1:0] fwd_data;

    // same-cycle forward, lowest write port has priority
    always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int i = NUM_WR - 1; i >= 0; i--)
        if (wr_live[i] && wa[i] == ra[k]) begin
          fwd_hit  = 1'b1;
          fwd_data = wd[i];
        end
    end

    if (BYPASS == 1) begin : g_byp
      assign rd[k]     = fwd_hit ? fwd_data
                       : (ra[k] == ZERO_ADDR) ? '0 : mem_q[ra[k]];
      assign rready[k] = !rd_busy[k] || fwd_hit;
    end else begin : g_nobyp
      logic unused_fwd;
      assign unused_fwd = fwd_hit ^ (^fwd_data);
      assign rd[k]      = (ra[k] == ZERO_ADDR) ? '0 : mem_q[ra[k]];
      assign rready[k]  = !rd_busy[k];
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: a BYPASS=1 and a BYPASS=0 instance share stimulus;
// expected outputs come from an array model and flow through a queue to a
// negedge monitor.
module tb_reg_file_mp;
  import rf_pkg::*;

  localparam int AW = 5, DW = 32, NR = 4, NW = 2;

  logic clk;
  logic rst;
  logic [NR-1:0][AW-1:0] raddr;
  logic [NW-1:0]         we;
  logic [NW-1:0][AW-1:0] waddr;
  logic [NW-1:0][DW-1:0] wdata;
  logic [NW-1:0]         iss_valid;
  logic [NW-1:0][AW-1:0] iss_rd;
  logic [AW-1:0]         dbg_addr;

  logic [NR*DW-1:0] rdata_b, rdata_n;
  logic [NR-1:0]    rready_b, rready_n;
  logic [DW-1:0]    dbg_b, dbg_n;
  logic             conf_b, conf_n;

  reg_file_mp #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_b), .rready(rready_b),
    .we(we), .waddr(waddr), .wdata(wdata), .iss_valid(iss_valid), .iss_rd(iss_rd),
    .dbg_addr(dbg_addr), .dbg_data(dbg_b), .wr_conflict(conf_b));

  reg_file_mp #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(0)) u_nob (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_n), .rready(rready_n),
    .we(we), .waddr(waddr), .wdata(wdata), .iss_valid(iss_valid), .iss_rd(iss_rd),
    .dbg_addr(dbg_addr), .dbg_data(dbg_n), .wr_conflict(conf_n));

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [NR-1:0][DW-1:0] rd_b;
    logic [NR-1:0][DW-1:0] rd_n;
    logic [NR-1:0]         rr_b;
    logic [NR-1:0]         rr_n;
    logic [DW-1:0]         dbg;
    logic                  conf;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // reference state
  logic [DW-1:0] m_mem [32];
  bit            m_busy[32];
  bit            m_conf;

  task automatic chk(input string name, input int port, input logic [DW-1:0] act, input logic [DW-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s[%0d] @%0t: got %h, expected %h", name, port, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [NR-1:0][DW-1:0] ab, an;
      e  = exp_q.pop_front();
      ab = rdata_b;
      an = rdata_n;
      for (int k = 0; k < NR; k++) begin
        chk("rdata_byp",  k, ab[k], e.rd_b[k]);
        chk("rdata_nob",  k, an[k], e.rd_n[k]);
        chk("rready_byp", k, {31'd0, rready_b[k]}, {31'd0, e.rr_b[k]});
        chk("rready_nob", k, {31'd0, rready_n[k]}, {31'd0, e.rr_n[k]});
      end
      chk("dbg_byp", 0, dbg_b, e.dbg);
      chk("dbg_nob", 0, dbg_n, e.dbg);
      chk("conflict_byp", 0, {31'd0, conf_b}, {31'd0, e.conf});
      chk("conflict_nob", 0, {31'd0, conf_n}, {31'd0, e.conf});
    end
  end

  task automatic idle();
    rst = 0; we = '0; waddr = '0; wdata = '0;
    iss_valid = '0; iss_rd = '0; raddr = '0; dbg_addr = '0;
  endtask

  function automatic logic [DW-1:0] stored(input int a);
    return (a == 0) ? '0 : m_mem[a];
  endfunction

  // One clock: predict this cycle's outputs, then apply the edge to the model.
  task automatic step(input bit check);
    exp_t e;
    bit [31:0] written;
    bit        nconf;
    e = '0;
    for (int k = 0; k < NR; k++) begin
      int a;
      bit fwd;
      logic [DW-1:0] fv;
      a = int'(raddr[k]);
      fwd = 0;
      fv = '0;
      for (int i = 0; i < NW; i++)
        if (!fwd && we[i] && waddr[i] != 0 && int'(waddr[i]) == a) begin
          fwd = 1; fv = wdata[i];
        end
      e.rd_n[k] = stored(a);
      e.rd_b[k] = fwd ? fv : stored(a);
      e.rr_n[k] = !m_busy[a];
      e.rr_b[k] = !m_busy[a] || fwd;
    end
    e.dbg  = stored(int'(dbg_addr));
    e.conf = m_conf;
    if (check) exp_q.push_back(e);
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < 32; r++) begin m_mem[r] = '0; m_busy[r] = 0; end
      m_conf = 0;
    end else begin
      written = '0;
      nconf = 0;
      for (int i = 0; i < NW; i++)
        if (we[i] && waddr[i] != 0) begin
          if (written[waddr[i]]) nconf = 1;
          else begin m_mem[waddr[i]] = wdata[i]; written[waddr[i]] = 1'b1; end
          m_busy[waddr[i]] = 0;
        end
      for (int j = 0; j < NW; j++)
        if (iss_valid[j] && iss_rd[j] != 0) m_busy[iss_rd[j]] = 1;
      m_conf = nconf;
    end
    #1;
  endtask

  initial begin
    #2;
    idle();
    rst = 1;
    step(0);

    // x5 busy and holding 0xDEAD, then reset over it
    idle(); we[0] = 1; waddr[0] = 5; wdata[0] = 32'hDEAD; iss_valid[1] = 1; iss_rd[1] = 5;
    step(1);
    idle(); raddr = {5'd5, 5'd0, 5'd5, 5'd5}; dbg_addr = 5;
    step(1);
    rst = 1;
    step(1);
    idle(); raddr = {5'd0, 5'd5, 5'd0, 5'd5}; dbg_addr = 5;
    step(1);

    // write then read the same cycle
    idle(); we[0] = 1; waddr[0] = AW'(A0_IDX); wdata[0] = 32'h1234_5678;
    raddr[0] = AW'(A0_IDX); dbg_addr = AW'(A0_IDX);
    step(1);
    idle(); raddr[0] = AW'(A0_IDX); dbg_addr = AW'(A0_IDX);
    step(1);

    // write conflict on x7
    idle(); we = 2'b11; waddr[0] = 7; waddr[1] = 7; wdata[0] = 32'hAAAA; wdata[1] = 32'hBBBB;
    step(1);
    idle(); raddr[0] = 7; dbg_addr = 7;
    step(1);
    idle(); raddr[0] = 7;
    step(1);

    // scoreboard on x3
    idle(); iss_valid[0] = 1; iss_rd[0] = 3;
    step(1);
    idle(); raddr[1] = 3;
    step(1);
    idle(); we[0] = 1; waddr[0] = 3; wdata[0] = 5; raddr[1] = 3;
    step(1);
    idle(); raddr[1] = 3;
    step(1);

    // set/clear collision on x4
    idle(); iss_valid[0] = 1; iss_rd[0] = 4; we[1] = 1; waddr[1] = 4; wdata[1] = 32'h4444;
    step(1);
    idle(); raddr[2] = 4; dbg_addr = 4;
    step(1);

    // register 0
    idle(); we = 2'b11; waddr[0] = 0; waddr[1] = 0; wdata[0] = 32'hFFFF; wdata[1] = 32'hFFFF;
    iss_valid = 2'b11; iss_rd[0] = 0; iss_rd[1] = 0;
    step(1);
    idle();
    step(1);

    // randomized traffic over a narrow address window to provoke clashes
    for (int n = 0; n < 400; n++) begin
      idle();
      rst = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < NW; i++) begin
        we[i]        = $urandom_range(0, 1);
        waddr[i]     = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
        wdata[i]     = $urandom;
        iss_valid[i] = ($urandom_range(0, 2) == 0);
        iss_rd[i]    = AW'($urandom_range(0, 7));
      end
      for (int k = 0; k < NR; k++) raddr[k] = AW'($urandom_range(0, 7));
      dbg_addr = AW'($urandom_range(0, 7));
      step(1);
    end

    idle();
    @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
